// File: rtl/fpdiv_seq.sv
// fpdiv_seq: control sequencer for a multiplier-based Goldschmidt divider.
// It walks the shared multiplier through the initial scaling, ITERS
// refinement iterations and a final remainder product. Every output is
// decoded from the registered state alone, so start has no combinational
// path to any output.
module fpdiv_seq #(
    parameter int ITERS = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic [1:0] sel_mux3,
    output logic [1:0] sel_mux4,
    output logic       en_a,
    output logic       en_b,
    output logic       en_rem,
    output logic       busy,
    output logic       done
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_INIT_N = 3'd1;
    localparam logic [2:0] S_INIT_D = 3'd2;
    localparam logic [2:0] S_ITER_N = 3'd3;
    localparam logic [2:0] S_ITER_D = 3'd4;
    localparam logic [2:0] S_REM    = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;

    // Iteration limit widened by one bit so the counter+1 comparison
    // cannot overflow, even at ITERS=7.
    localparam logic [3:0] ITERS_W = 4'(ITERS);

    logic [2:0] state_reg, state_next;
    logic [2:0] cnt_reg, cnt_next;
    logic [3:0] cnt_inc;

    assign cnt_inc = {1'b0, cnt_reg} + 4'd1;

    // Next-state and iteration-counter logic.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    state_next = S_INIT_N;
                    cnt_next   = 3'd0;
                end
            end
            S_INIT_N: state_next = S_INIT_D;
            S_INIT_D: state_next = (ITERS_W != 4'd0) ? S_ITER_N : S_REM;
            S_ITER_N: state_next = S_ITER_D;
            S_ITER_D: begin
                // Count only when another iteration follows, so the
                // counter tops out at ITERS-1 and never wraps.
                if (cnt_inc < ITERS_W) begin
                    state_next = S_ITER_N;
                    cnt_next   = cnt_inc[2:0];
                end else begin
                    state_next = S_REM;
                end
            end
            S_REM: state_next = S_DONE;
            S_DONE: begin
                if (start) begin
                    state_next = S_INIT_N;
                    cnt_next   = 3'd0;
                end else begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
                cnt_next   = 3'd0;
            end
        endcase
    end

    // State and counter registers; reset low forces IDLE and ignores start.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= S_IDLE;
            cnt_reg   <= 3'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Moore output decode from the registered state.
    always_comb begin
        sel_mux3 = 2'b00;
        sel_mux4 = 2'b00;
        en_a     = 1'b0;
        en_b     = 1'b0;
        en_rem   = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state_reg)
            S_INIT_N: begin
                sel_mux4 = 2'b00;
                en_a     = 1'b1;
                busy     = 1'b1;
            end
            S_INIT_D: begin
                sel_mux4 = 2'b01;
                en_b     = 1'b1;
                busy     = 1'b1;
            end
            S_ITER_N: begin
                sel_mux3 = 2'b01;
                sel_mux4 = 2'b10;
                en_a     = 1'b1;
                busy     = 1'b1;
            end
            S_ITER_D: begin
                sel_mux3 = 2'b01;
                sel_mux4 = 2'b11;
                en_b     = 1'b1;
                busy     = 1'b1;
            end
            S_REM: begin
                sel_mux3 = 2'b10;
                sel_mux4 = 2'b10;
                en_rem   = 1'b1;
                busy     = 1'b1;
            end
            S_DONE: done = 1'b1;
            default: ;
        endcase
    end

endmodule
